// File: rtl/mem_sync_param.sv
// Parametrised synchronous single-port memory with a reset-driven fill sequencer,
// a pipelined read-valid strobe and an error strobe for illegal requests.
module mem_sync_param #(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           ADDR_WIDTH   = 5,
    parameter int unsigned           DEPTH        = 32,
    parameter int unsigned           READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int unsigned           IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        cnt_q;
    logic                    busy_q;
    logic                    err_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   data_out_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    ready;
    logic                    req;
    logic                    in_range;
    logic [IDX_W-1:0]        addr_idx;
    logic                    rd_fire;
    logic                    wr_fire;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data;

    assign ready    = (state_q == StReady);
    assign req      = read | write;
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign addr_idx = addr[IDX_W-1:0];
    assign rd_fire  = ready & read & ~write;
    assign wr_fire  = ready & write & ~read & in_range;
    assign illegal  = req & (~ready | (read & write) | ~in_range);
    // Out-of-range reads still complete, but return zero.
    assign rd_word  = in_range ? mem[addr_idx] : '0;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VALUE;
        if (!ready) begin
            mem_we = 1'b1;
        end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = addr_idx;
            mem_wdata = data_in;
        end
    end

    // Array is not reset; a write coinciding with reset assertion is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            err_q <= illegal;
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                StReady: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= StInit;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_valid_q;
        logic [DATA_WIDTH-1:0] s1_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_fire;
                if (rd_fire) begin
                    s1_data_q <= rd_word;
                end
            end
        end

        assign pipe_valid = s1_valid_q;
        assign pipe_data  = s1_data_q;
    end else begin : g_lat1
        assign pipe_valid = rd_fire;
        assign pipe_data  = rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            rd_valid_q <= pipe_valid;
            if (pipe_valid) begin
                data_out_q <= pipe_data;
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_sync_param.sv
// Scoreboard bench: two memory configurations driven in lockstep, expectations queued
// from a behavioural model and popped by a negedge monitor.
module tb_mem_sync_param;
    localparam int NU  = 2;
    localparam int BIG = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [15:0] data_in;

    logic [7:0]  dout_a;
    logic        rdv_a, busy_a, err_a;
    logic [15:0] dout_b;
    logic        rdv_b, busy_b, err_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sync_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(20), .READ_LATENCY(1), .INIT_VALUE(8'hA5)
    ) dut_a (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .data_in(data_in[7:0]), .data_out(dout_a), .rd_valid(rdv_a), .busy(busy_a),
        .err(err_a)
    );

    mem_sync_param #(
        .DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(32), .READ_LATENCY(2), .INIT_VALUE(16'h5A3C)
    ) dut_b (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(dout_b), .rd_valid(rdv_b), .busy(busy_b), .err(err_b)
    );

    // Reference model
    int          depth_m [NU] = '{20, 32};
    int          lat_m   [NU] = '{1, 2};
    logic [15:0] init_m  [NU] = '{16'h00A5, 16'h5A3C};
    logic [15:0] mask_m  [NU] = '{16'h00FF, 16'hFFFF};
    logic [15:0] mem_m   [NU][32];
    int          ready_edge [NU];
    logic [15:0] hold [NU];

    int          rd_cyc [NU][64];
    logic [15:0] rd_dat [NU][64];
    int          rd_wp [NU];
    int          rd_rp [NU];
    int          er_cyc [NU][64];
    int          er_wp [NU];
    int          er_rp [NU];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", name, u, cyc, act, exp);
    endtask

    task automatic push_rd(input int u, input int c, input logic [15:0] d);
        rd_cyc[u][rd_wp[u] % 64] = c;
        rd_dat[u][rd_wp[u] % 64] = d;
        rd_wp[u]++;
    endtask

    task automatic push_err(input int u, input int c);
        er_cyc[u][er_wp[u] % 64] = c;
        er_wp[u]++;
    endtask

    // k is the edge number that samples the request.
    task automatic model(input int u, input int k, input logic rd, input logic wr,
                         input logic [4:0] a, input logic [15:0] d);
        if (rd || wr) begin
            if (k < ready_edge[u] || (rd && wr)) begin
                push_err(u, k);
            end else if (int'(a) >= depth_m[u]) begin
                push_err(u, k);
                if (rd) push_rd(u, k + lat_m[u] - 1, 16'h0000);
            end else if (wr) begin
                mem_m[u][a] = d & mask_m[u];
            end else begin
                push_rd(u, k + lat_m[u] - 1, mem_m[u][a]);
            end
        end
    endtask

    task automatic mon(input int u, input logic rdv, input logic [15:0] dout, input logic e,
                       input logic b);
        logic exp_v;
        logic exp_e;
        logic exp_b;
        while (rd_rp[u] != rd_wp[u] && rd_cyc[u][rd_rp[u] % 64] < cyc) begin
            chk("rd_lost", u, rd_cyc[u][rd_rp[u] % 64], cyc);
            rd_rp[u]++;
        end
        exp_v = (rd_rp[u] != rd_wp[u]) && (rd_cyc[u][rd_rp[u] % 64] == cyc);
        chk("rd_valid", u, {31'b0, rdv}, {31'b0, exp_v});
        if (exp_v) begin
            hold[u] = rd_dat[u][rd_rp[u] % 64];
            rd_rp[u]++;
        end
        chk("data_out", u, {16'b0, dout}, {16'b0, hold[u]});

        while (er_rp[u] != er_wp[u] && er_cyc[u][er_rp[u] % 64] < cyc) begin
            chk("err_lost", u, er_cyc[u][er_rp[u] % 64], cyc);
            er_rp[u]++;
        end
        exp_e = (er_rp[u] != er_wp[u]) && (er_cyc[u][er_rp[u] % 64] == cyc);
        chk("err", u, {31'b0, e}, {31'b0, exp_e});
        if (exp_e) er_rp[u]++;

        exp_b = rst || (cyc < ready_edge[u] - 1);
        chk("busy", u, {31'b0, b}, {31'b0, exp_b});
    endtask

    always @(negedge clk) begin
        mon(0, rdv_a, {8'h00, dout_a}, err_a, busy_a);
        mon(1, rdv_b, dout_b, err_b, busy_b);
    end

    task automatic issue(input logic rd, input logic wr, input logic [4:0] a,
                         input logic [15:0] d);
        int k;
        k       = cyc + 1;
        read    = rd;
        write   = wr;
        addr    = a;
        data_in = d;
        for (int u = 0; u < NU; u++) model(u, k, rd, wr, a, d);
        @(negedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 5'd0, 16'h0000);
    endtask

    task automatic rd_at(input logic [4:0] a);
        issue(1'b1, 1'b0, a, 16'h0000);
    endtask

    task automatic wr_at(input logic [4:0] a, input logic [15:0] d);
        issue(1'b0, 1'b1, a, d);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        for (int u = 0; u < NU; u++) begin
            rd_rp[u]      = rd_wp[u];
            er_rp[u]      = er_wp[u];
            hold[u]       = 16'h0000;
            ready_edge[u] = BIG;
        end
        repeat (2) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_release();
        rst = 1'b0;
        for (int u = 0; u < NU; u++) begin
            ready_edge[u] = cyc + 1 + depth_m[u];
            for (int i = 0; i < 32; i++) mem_m[u][i] = init_m[u];
        end
    endtask

    task automatic wait_ready();
        while (cyc + 1 < ready_edge[1]) idle();
    endtask

    initial begin
        int          op;
        logic [4:0]  ra;
        logic [15:0] rdat;
        rst     = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
        for (int u = 0; u < NU; u++) begin
            rd_wp[u] = 0; rd_rp[u] = 0; er_wp[u] = 0; er_rp[u] = 0;
            hold[u] = 16'h0000;
            ready_edge[u] = BIG;
        end
        #2;
        do_reset();
        do_release();

        // Requests while the fill sequencer runs are dropped with an error.
        wr_at(5'd3, 16'hDEAD);
        rd_at(5'd3);
        wait_ready();

        for (int i = 0; i < 32; i++) rd_at(5'(i));

        wr_at(5'd7, 16'h003C);
        rd_at(5'd7);
        idle();
        idle();

        wr_at(5'd1, 16'h1111);
        wr_at(5'd2, 16'h2222);
        wr_at(5'd3, 16'h3333);
        rd_at(5'd1);
        rd_at(5'd2);
        rd_at(5'd3);

        wr_at(5'd4, 16'h0055);
        issue(1'b1, 1'b1, 5'd4, 16'h00FF);
        rd_at(5'd4);

        wr_at(5'd25, 16'h0077);
        rd_at(5'd25);
        wr_at(5'd19, 16'h0099);
        rd_at(5'd19);
        idle();
        idle();

        for (int i = 0; i < 300; i++) begin
            op   = int'($urandom_range(0, 9));
            ra   = 5'($urandom_range(0, 31));
            rdat = 16'($urandom);
            issue((op <= 3) || (op == 7), (op >= 4) && (op <= 7), ra, rdat);
        end

        // Reset one cycle after a read: the latency-2 read must vanish.
        rd_at(5'd5);
        do_reset();
        do_release();
        wait_ready();
        for (int i = 0; i < 8; i++) rd_at(5'(i));
        rd_at(5'd19);
        rd_at(5'd25);
        repeat (4) idle();

        for (int u = 0; u < NU; u++) begin
            chk("rd_drain", u, rd_wp[u] - rd_rp[u], 0);
            chk("err_drain", u, er_wp[u] - er_rp[u], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
